// File: rtl/disp_pkg.sv
// Shared definitions for the multiplexed 4-digit display scheduler:
// FSM encoding, anode codes and the default hold length.
package disp_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BLANK = 2'd1,
        ST_SHOW  = 2'd2
    } state_t;

    localparam logic [3:0] AN_POS0  = 4'b1110;
    localparam logic [3:0] AN_POS1  = 4'b1101;
    localparam logic [3:0] AN_POS2  = 4'b1011;
    localparam logic [3:0] AN_POS3  = 4'b0111;
    localparam logic [3:0] AN_BLANK = 4'b1111;

    localparam int HOLD_FRAMES_DEF = 8;

    function automatic logic [3:0] an_code(input logic [1:0] pos);
        case (pos)
            2'd0:    an_code = AN_POS0;
            2'd1:    an_code = AN_POS1;
            2'd2:    an_code = AN_POS2;
            default: an_code = AN_POS3;
        endcase
    endfunction

endpackage

// File: rtl/disp_sched_rr_arb2.sv
// Two-requester round-robin decision: a lone request wins, a tie goes to
// the requester that did not own the display last.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last_owner,
    output logic       valid,
    output logic       winner
);

    always_comb begin
        valid = |req;
        case (req)
            2'b01:   winner = 1'b0;
            2'b10:   winner = 1'b1;
            2'b11:   winner = ~last_owner;
            default: winner = 1'b0;
        endcase
    end

endmodule

// File: rtl/disp_sched.sv
// Display scheduler: arbitrates two requesters at frame boundaries, latches
// the winner's digits and scans them onto a 4-digit multiplexed display.
module disp_sched
    import disp_pkg::*;
#(
    parameter int HOLD_FRAMES = HOLD_FRAMES_DEF
) (
    input  logic        Reset,
    input  logic        slow_clk,
    input  logic [1:0]  req,
    input  logic [15:0] data0,
    input  logic [15:0] data1,
    output logic [1:0]  gnt,
    output logic        owner,
    output logic        busy,
    output logic [1:0]  sel,
    output logic [3:0]  AN,
    output logic [3:0]  digit
);

    localparam logic [7:0] HOLD_LAST = 8'(HOLD_FRAMES - 1);
    localparam logic [7:0] HOLD_MAX  = 8'(HOLD_FRAMES);

    state_t      state_q, state_d;
    logic [1:0]  sel_q;
    logic [1:0]  gnt_q;
    logic [1:0]  gnt_d;
    logic        owner_q;
    logic        last_owner_q;
    logic [15:0] data_q;
    logic [7:0]  hold_q;

    logic frame_end;
    logic hold_exp;
    logic arb_valid;
    logic arb_winner;
    logic grant;

    rr_arb2 u_arb (
        .req        (req),
        .last_owner (last_owner_q),
        .valid      (arb_valid),
        .winner     (arb_winner)
    );

    assign frame_end = (sel_q == 2'd3);
    // hold_q counts completed SHOW frames; expiry is seen at the edge closing the last one
    assign hold_exp  = (hold_q >= HOLD_LAST);
    assign grant     = frame_end && arb_valid &&
                       ((state_q == ST_IDLE) || ((state_q == ST_SHOW) && hold_exp));

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_gnt
            assign gnt_d[gi] = grant && (arb_winner == 1'(gi));
        end
    endgenerate

    always_ff @(posedge slow_clk or posedge Reset) begin
        if (Reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (grant) state_d = ST_BLANK;
            ST_BLANK: if (frame_end) state_d = ST_SHOW;
            ST_SHOW:  if (grant && (arb_winner != owner_q)) state_d = ST_BLANK;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge slow_clk or posedge Reset) begin
        if (Reset) begin
            sel_q        <= 2'd0;
            gnt_q        <= 2'b00;
            owner_q      <= 1'b0;
            last_owner_q <= 1'b1;
            data_q       <= 16'h0000;
            hold_q       <= 8'd0;
        end else begin
            sel_q <= sel_q + 2'd1;
            gnt_q <= gnt_d;
            if (grant) begin
                data_q       <= arb_winner ? data1 : data0;
                owner_q      <= arb_winner;
                last_owner_q <= arb_winner;
            end
            // Any grant or the end of a blank frame leads into a fresh SHOW period
            if (grant || (frame_end && (state_q == ST_BLANK))) begin
                hold_q <= 8'd0;
            end else if (frame_end && (state_q == ST_SHOW) && (hold_q < HOLD_MAX)) begin
                hold_q <= hold_q + 8'd1;
            end
        end
    end

    always_comb begin
        busy  = (state_q == ST_SHOW);
        AN    = AN_BLANK;
        digit = 4'h0;
        if (busy) begin
            AN = an_code(sel_q);
            case (sel_q)
                2'd0:    digit = data_q[3:0];
                2'd1:    digit = data_q[7:4];
                2'd2:    digit = data_q[11:8];
                default: digit = data_q[15:12];
            endcase
        end
    end

    assign gnt   = gnt_q;
    assign owner = owner_q;
    assign sel   = sel_q;

endmodule
